fmul_iter: RTL

- Iterative floating-point multiplier for the MIX 31-bit float word. It is the multiplicative counterpart of the FPU's iterative divider and sits beside it in the FPU.
- Word format: bit 30 sign; [29:24] exponent, excess 040 (octal); [23:0] fraction of 8 octal digits.
- Operation is shift-and-add, one octal multiplier digit per cycle, followed by a single normalize step.
- Uses the FPU's start/stop pulse handshake. The second operand arrives one cycle after start, at the same operand-fetch timing as the divider.

---
 rtl/mix_fp_pkg.sv | 19 +
 rtl/fmul_iter_oct_mac.sv | 21 ++
 rtl/fmul_iter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mix_fp_pkg.sv
// Shared MIX float field layout and sequencer state encoding for the FPU blocks.
package mix_fp_pkg;

  localparam int SIGN_BIT = 30;
  localparam int EXP_MSB  = 29;
  localparam int EXP_LSB  = 24;
  localparam int FRAC_W   = 24;
  localparam int EXP_BIAS = 'o40;
  localparam int EXP_MAX  = 63;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ONE  = 3'd1,
    S_ACC  = 3'd2,
    S_NORM = 3'd3,
    S_DONE = 3'd4
  } fpu_state_t;

endpackage

// File: rtl/fmul_iter_oct_mac.sv
// Octal multiply-accumulate: sum = p_hi + a*d for one 3-bit digit d,
// formed from shifted copies of a so the divider can reuse it for multiples.
module oct_mac
  import mix_fp_pkg::*;
(
  input  logic [FRAC_W-1:0] a,
  input  logic [FRAC_W-1:0] p_hi,
  input  logic [2:0]        d,
  output logic [FRAC_W+2:0] sum
);

  logic [FRAC_W+2:0] m0;
  logic [FRAC_W+2:0] m1;
  logic [FRAC_W+2:0] m2;

  assign m0  = d[0] ? {3'b000, a}        : '0;
  assign m1  = d[1] ? {2'b00, a, 1'b0}   : '0;
  assign m2  = d[2] ? {1'b0, a, 2'b00}   : '0;
  assign sum = {3'b000, p_hi} + m0 + m1 + m2;

endmodule

// File: rtl/fmul_iter.sv
// Iterative MIX float multiplier: one octal multiplier digit per cycle,
// then a single normalize step. Result lands 11 cycles after start.
module fmul_iter #(
  parameter int FRAC_DIGITS = 8,
  parameter int EXP_BIAS    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [30:0] multiplicand,
  input  logic [30:0] multiplier,
  output logic        busy,
  output logic        stop,
  output logic [30:0] out,
  output logic        overflow,
  output logic [2:0]  dbg_state
);

  import mix_fp_pkg::*;

  // Handshake: start is a one-cycle pulse with multiplicand valid in that
  // cycle; multiplier is taken the following cycle. start in any state
  // (including DONE) begins a new operation. stop pulses for one cycle when
  // out/overflow have just been updated; busy covers ONE..NORM.

  localparam logic [2:0]        LAST_DIGIT = 3'(FRAC_DIGITS - 1);
  localparam logic [7:0]        BIAS8      = 8'(EXP_BIAS);
  localparam logic signed [7:0] EXP_MAX8   = 8'(EXP_MAX);

  fpu_state_t state_q, state_d;

  logic [FRAC_W-1:0]   a_q;
  logic [FRAC_W-1:0]   b_q;
  logic [2*FRAC_W-1:0] p_q;
  logic [2:0]          cnt_q;
  logic                sign_q;
  logic                zero_q;
  logic [7:0]          exp_q;
  logic [30:0]         out_q;
  logic                ovf_q;

  logic [FRAC_W+2:0]   mac_sum;
  logic [FRAC_W-1:0]   frac_n;
  logic signed [7:0]   exp_n;
  logic                ovf_n;

  oct_mac u_mac (
    .a    (a_q),
    .p_hi (p_q[2*FRAC_W-1:FRAC_W]),
    .d    (b_q[2:0]),
    .sum  (mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_ONE:   state_d = S_ACC;
      S_ACC:   if (cnt_q == LAST_DIGIT) state_d = S_NORM;
      S_NORM:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start) state_d = S_ONE;
  end

  // Single-step normalize: a zero top digit costs one digit of exponent.
  always_comb begin
    if (p_q[2*FRAC_W-1 -: 3] == 3'b000) begin
      frac_n = p_q[2*FRAC_W-4 -: FRAC_W];
      exp_n  = $signed(exp_q - 8'd1);
    end else begin
      frac_n = p_q[2*FRAC_W-1 -: FRAC_W];
      exp_n  = $signed(exp_q);
    end
    ovf_n = (exp_n < 0) || (exp_n > EXP_MAX8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      exp_q  <= '0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      a_q    <= multiplicand[FRAC_W-1:0];
      sign_q <= multiplicand[SIGN_BIT];
      exp_q  <= {2'b00, multiplicand[EXP_MSB:EXP_LSB]};
      p_q    <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        S_ONE: begin
          b_q    <= multiplier[FRAC_W-1:0];
          sign_q <= sign_q ^ multiplier[SIGN_BIT];
          exp_q  <= exp_q + {2'b00, multiplier[EXP_MSB:EXP_LSB]} - BIAS8;
          zero_q <= (a_q == '0) || (multiplier[FRAC_W-1:0] == '0);
        end
        S_ACC: begin
          p_q   <= (2*FRAC_W)'({mac_sum, p_q[FRAC_W-1:0]} >> 3);
          b_q   <= b_q >> 3;
          cnt_q <= cnt_q + 3'd1;
        end
        S_NORM: begin
          if (zero_q) begin
            out_q <= {sign_q, 30'd0};
            ovf_q <= 1'b0;
          end else begin
            out_q <= {sign_q, exp_n[5:0], frac_n};
            ovf_q <= ovf_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == S_ONE) || (state_q == S_ACC) || (state_q == S_NORM);
  assign stop      = (state_q == S_DONE);
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule
